keypad_scan_bcd: RTL and testbench

4x4 matrix keypad scanner and debouncer feeding the 4-digit BCD entry register consumed by the 7-segment display driver. It strobes keypad columns, samples rows and validates a single key press over several full scans. Each accepted press is emitted as a one-cycle key event, and digit keys shift into BCD0..BCD3 for direct connection to the display multiplexer's digit inputs.

---
 rtl/keypad_scan_bcd.sv | 232 +++++++++++++++++++++++
 tb/tb_keypad_scan_bcd.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_bcd.sv
// 4x4 keypad scanner/debouncer driving a 4-digit BCD entry register.
// Optional KBD_AUTOREPEAT_EN adds held-key repeat events every REPEAT_SCANS scans.
module keypad_scan_bcd #(
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_SCANS   = 32
) (
  input  logic       clk_out_kbd,
  input  logic       reset,
  input  logic [3:0] Row,
  output logic [3:0] Col,
  output logic [3:0] BCD0,
  output logic [3:0] BCD1,
  output logic [3:0] BCD2,
  output logic [3:0] BCD3,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_SCANS);

  if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1 || REPEAT_SCANS > 255) begin : g_bad_param
    $error("keypad_scan_bcd: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, CANDIDATE, PRESSED} state_t;

  logic [3:0] row_sync1_reg, row_sync2_reg;
  logic [3:0] cnt_reg;
  logic [1:0] acc_cnt_reg, merged_cnt;
  logic [3:0] acc_code_reg, merged_code;
  logic [3:0] row_hit;
  logic [2:0] col_cnt;
  logic [1:0] row_idx;
  logic       scan_done, res_none, res_one;

  state_t     state_reg, state_next;
  logic [3:0] sc_reg, sc_next, sc_inc;
  logic [3:0] cand_reg, cand_next;
  logic       accept, rep_fire;
  logic [3:0] accept_code;

  logic       key_valid_reg;
  logic [3:0] key_code_reg;
  logic [3:0] digit_reg [0:3];

  assign Col       = ~(4'b0001 << cnt_reg[3:2]);
  assign row_hit   = ~row_sync2_reg;
  assign col_cnt   = {2'b00, row_hit[0]} + {2'b00, row_hit[1]} + {2'b00, row_hit[2]} + {2'b00, row_hit[3]};
  assign scan_done = (cnt_reg == 4'd15);
  assign res_none  = (merged_cnt == 2'd0);
  assign res_one   = (merged_cnt == 2'd1);
  assign sc_inc    = sc_reg + 4'd1;

  always_comb begin
    row_idx = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (row_hit[r]) row_idx = 2'(r);
    end
  end

  // Key count saturates at 2 (MULTI); the code is only meaningful when exactly one key was seen.
  always_comb begin
    merged_cnt  = acc_cnt_reg;
    merged_code = acc_code_reg;
    if (cnt_reg[1:0] == 2'd3) begin
      if (col_cnt == 3'd1 && acc_cnt_reg == 2'd0) begin
        merged_cnt  = 2'd1;
        merged_code = {row_idx, cnt_reg[3:2]};
      end else if (col_cnt != 3'd0) begin
        merged_cnt = 2'd2;
      end
    end
  end

  always_ff @(posedge clk_out_kbd or negedge reset) begin
    if (!reset) begin
      row_sync1_reg <= 4'b1111;
      row_sync2_reg <= 4'b1111;
      cnt_reg       <= 4'd0;
      acc_cnt_reg   <= 2'd0;
      acc_code_reg  <= 4'd0;
    end else begin
      row_sync1_reg <= Row;
      row_sync2_reg <= row_sync1_reg;
      cnt_reg       <= cnt_reg + 4'd1;
      acc_cnt_reg   <= scan_done ? 2'd0 : merged_cnt;
      acc_code_reg  <= scan_done ? 4'd0 : merged_code;
    end
  end

`ifdef KBD_AUTOREPEAT_EN
  localparam logic [7:0] REP = 8'(REPEAT_SCANS);
  logic [7:0] rep_reg, rep_next;

  always_ff @(posedge clk_out_kbd or negedge reset) begin
    if (!reset) rep_reg <= 8'd0;
    else        rep_reg <= rep_next;
  end

  always_comb begin
    rep_next = rep_reg;
    rep_fire = 1'b0;
    if (state_reg != PRESSED) begin
      rep_next = 8'd0;
    end else if (scan_done) begin
      if (res_one && merged_code == cand_reg) begin
        if (rep_reg + 8'd1 == REP) begin
          rep_next = 8'd0;
          rep_fire = 1'b1;
        end else begin
          rep_next = rep_reg + 8'd1;
        end
      end else begin
        rep_next = 8'd0;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk_out_kbd or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sc_reg    <= 4'd0;
      cand_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      sc_reg    <= sc_next;
      cand_reg  <= cand_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    sc_next    = sc_reg;
    cand_next  = cand_reg;
    if (scan_done) begin
      case (state_reg)
        IDLE: begin
          if (res_one) begin
            cand_next = merged_code;
            if (DEB == 4'd1) begin
              state_next = PRESSED;
              sc_next    = 4'd0;
            end else begin
              state_next = CANDIDATE;
              sc_next    = 4'd1;
            end
          end
        end
        CANDIDATE: begin
          if (!res_one) begin
            state_next = IDLE;
            sc_next    = 4'd0;
          end else if (merged_code != cand_reg) begin
            cand_next = merged_code;
            sc_next   = 4'd1;
          end else if (sc_inc == DEB) begin
            state_next = PRESSED;
            sc_next    = 4'd0;
          end else begin
            sc_next = sc_inc;
          end
        end
        PRESSED: begin
          if (!res_none) begin
            sc_next = 4'd0;
          end else if (sc_inc == DEB) begin
            state_next = IDLE;
            sc_next    = 4'd0;
          end else begin
            sc_next = sc_inc;
          end
        end
        default: begin
          state_next = IDLE;
          sc_next    = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    accept      = 1'b0;
    accept_code = cand_reg;
    if (scan_done && res_one) begin
      if (state_reg == IDLE && DEB == 4'd1) begin
        accept      = 1'b1;
        accept_code = merged_code;
      end else if (state_reg == CANDIDATE && merged_code == cand_reg && sc_inc == DEB) begin
        accept = 1'b1;
      end
    end
    if (rep_fire) accept = 1'b1;
  end

  // Entry register: digits shift in from the right, backspace shifts back out.
  always_ff @(posedge clk_out_kbd or negedge reset) begin
    if (!reset) begin
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'd0;
      for (int i = 0; i < 4; i++) digit_reg[i] <= 4'hF;
    end else begin
      key_valid_reg <= accept;
      if (accept) begin
        key_code_reg <= accept_code;
        if (accept_code <= 4'd9) begin
          digit_reg[0] <= digit_reg[1];
          digit_reg[1] <= digit_reg[2];
          digit_reg[2] <= digit_reg[3];
          digit_reg[3] <= accept_code;
        end else if (accept_code == 4'hA) begin
          for (int i = 0; i < 4; i++) digit_reg[i] <= 4'hF;
        end else if (accept_code == 4'hB) begin
          digit_reg[3] <= digit_reg[2];
          digit_reg[2] <= digit_reg[1];
          digit_reg[1] <= digit_reg[0];
          digit_reg[0] <= 4'hF;
        end
      end
    end
  end

  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign BCD0      = digit_reg[0];
  assign BCD1      = digit_reg[1];
  assign BCD2      = digit_reg[2];
  assign BCD3      = digit_reg[3];

endmodule

// File: tb/tb_keypad_scan_bcd.sv
// Scoreboard bench for keypad_scan_bcd: a scan-level keypad model predicts events and entry digits.
module tb_keypad_scan_bcd;
  localparam int D = 4;
  localparam int R = 32;

  logic        clk_out_kbd = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  Row, Col, BCD0, BCD1, BCD2, BCD3, key_code;
  logic        key_valid;
  logic [15:0] mask = 16'h0;
  int          cyc;
  int          compared = 0;
  int          mismatched = 0;

  typedef struct {
    int          t;
    logic [3:0]  code;
    logic [15:0] digs;
  } exp_t;
  exp_t q[$];

  bit         held;
  int         run_code, run_len, none_run, scan_no;
  logic [3:0] md [0:3];
`ifdef KBD_AUTOREPEAT_EN
  int         rep;
`endif

  keypad_scan_bcd #(.DEBOUNCE_SCANS(D), .REPEAT_SCANS(R)) dut (
    .clk_out_kbd(clk_out_kbd), .reset(reset), .Row(Row), .Col(Col),
    .BCD0(BCD0), .BCD1(BCD1), .BCD2(BCD2), .BCD3(BCD3),
    .key_code(key_code), .key_valid(key_valid)
  );

  always #5 clk_out_kbd = ~clk_out_kbd;

  // Physical keypad: a pressed key pulls its row low while its column is strobed.
  always_comb begin
    Row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!Col[c] && mask[r*4+c]) Row[r] = 1'b0;
  end

  always @(posedge clk_out_kbd or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every key_valid pulse must match the next predicted event, in time and content.
  always @(negedge clk_out_kbd) begin
    if (reset && key_valid) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_event: got code %h at cycle %0d, expected no event", key_code, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("event_cycle", 16'(cyc), 16'(e.t));
        check("key_code", {12'h0, key_code}, {12'h0, e.code});
        check("digits", {BCD0, BCD1, BCD2, BCD3}, e.digs);
        $display("event t=%0d code=%h digits=%h%h%h%h", cyc, key_code, BCD0, BCD1, BCD2, BCD3);
      end
    end
  end

  task automatic model_reset();
    held = 0; run_code = 0; run_len = 0; none_run = 0; scan_no = 0;
    for (int i = 0; i < 4; i++) md[i] = 4'hF;
`ifdef KBD_AUTOREPEAT_EN
    rep = 0;
`endif
  endtask

  task automatic emit(input int k);
    if (k <= 9) begin
      md[0] = md[1]; md[1] = md[2]; md[2] = md[3]; md[3] = 4'(k);
    end else if (k == 10) begin
      for (int i = 0; i < 4; i++) md[i] = 4'hF;
    end else if (k == 11) begin
      md[3] = md[2]; md[2] = md[1]; md[1] = md[0]; md[0] = 4'hF;
    end
    q.push_back('{t: 16 * scan_no, code: 4'(k), digs: {md[0], md[1], md[2], md[3]}});
  endtask

  // A key is accepted after D consecutive single-key scans of the same key and
  // released after D consecutive empty scans.
  task automatic model_scan(input logic [15:0] m);
    int n, k;
    n = $countones(m);
    k = 0;
    for (int i = 0; i < 16; i++) if (m[i]) k = i;
    scan_no++;
    if (!held) begin
      if (n == 1) begin
        if (run_len > 0 && k == run_code) run_len++;
        else begin run_code = k; run_len = 1; end
        if (run_len >= D) begin
          held = 1; none_run = 0;
`ifdef KBD_AUTOREPEAT_EN
          rep = 0;
`endif
          emit(run_code);
        end
      end else run_len = 0;
    end else if (n == 0) begin
      none_run++;
`ifdef KBD_AUTOREPEAT_EN
      rep = 0;
`endif
      if (none_run >= D) begin held = 0; run_len = 0; end
    end else begin
      none_run = 0;
`ifdef KBD_AUTOREPEAT_EN
      if (n == 1 && k == run_code) begin
        rep++;
        if (rep == R) begin rep = 0; emit(run_code); end
      end else rep = 0;
`endif
    end
  endtask

  task automatic run_scans(input logic [15:0] m, input int n);
    for (int s = 0; s < n; s++) begin
      mask = m;
      repeat (16) @(posedge clk_out_kbd);
      #1;
      model_scan(m);
    end
  endtask

  task automatic press(input int k);
    run_scans(16'(1) << k, D + 1);
    run_scans(16'h0, D + 1);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_col", {12'h0, Col}, 16'h000E);
    check("reset_bcd", {BCD0, BCD1, BCD2, BCD3}, 16'hFFFF);
    check("reset_valid", {15'h0, key_valid}, 16'h0);
    check("reset_code", {12'h0, key_code}, 16'h0);
    @(negedge clk_out_kbd);
    reset = 1'b1;

    run_scans(16'h0040, 10);           // row 1 / column 2 held
    run_scans(16'h0, D + 2);
    for (int k = 1; k <= 5; k++) press(k);
    press(10);
    press(1); press(2); press(3); press(11); press(10);
    for (int s = 0; s < 12; s++) run_scans((s % 2 == 0) ? 16'h0020 : 16'h0, 1);
    run_scans(16'h0208, 10);           // keys 3 and 9 together
    run_scans(16'h0, D + 1);
    run_scans(16'h0080, D + 100);      // key 7 held long
    run_scans(16'h0, D + 1);

    // Asynchronous reset in the middle of a debounce
    mask = 16'h0010;
    repeat (16 * 2 + 7) @(posedge clk_out_kbd);
    #2 reset = 1'b0;
    #1;
    check("midreset_col", {12'h0, Col}, 16'h000E);
    check("midreset_bcd", {BCD0, BCD1, BCD2, BCD3}, 16'hFFFF);
    check("midreset_valid", {15'h0, key_valid}, 16'h0);
    check("midreset_queue", 16'(q.size()), 16'h0);
    model_reset();
    repeat (3) @(negedge clk_out_kbd);
    reset = 1'b1;
    press(8);
    press(4);

    for (int seg = 0; seg < 60; seg++) begin
      logic [15:0] m;
      int sel, len;
      sel = $urandom_range(0, 9);
      len = $urandom_range(1, 8);
      if (sel < 3)      m = 16'h0;
      else if (sel < 8) m = 16'(1) << $urandom_range(0, 15);
      else              m = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      run_scans(m, len);
    end
    run_scans(16'h0, D + 1);
    repeat (4) @(posedge clk_out_kbd);
    #1;
    check("final_queue", 16'(q.size()), 16'h0);
    check("final_digits", {BCD0, BCD1, BCD2, BCD3}, {md[0], md[1], md[2], md[3]});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
